// File: rtl/spi_master.sv
// spi_master: 3-wire SPI initiator for the 16 x 20-bit register slave.
// Turns a parallel request into a write frame (flag, addr, data) or a read
// frame (flag, addr, turnaround, 20 data bits from the slave). Every frame
// is followed by a GAP of two idle sclk periods with ss low, which clears
// the slave's bit counter. The same GAP is used as the flush after reset.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rw,
  input  logic [3:0]  addr,
  input  logic [19:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [19:0] rdata,
  output logic        spi_ss,
  output logic        spi_sclk,
  inout  wire         spi_sda
);

  // One sclk period is 2*CLK_DIV clk cycles; the phase counter covers it.
  localparam int CNT_W = $clog2(2 * CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LOW_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(2 * CLK_DIV - 1);

  localparam logic [4:0] WR_SLOTS   = 5'd25;
  localparam logic [4:0] RD_SLOTS   = 5'd27;
  localparam logic [4:0] ADDR_LAST  = 5'd5;
  localparam logic [4:0] SAMP_FIRST = 5'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       slot_q, slot_d;
  logic             rw_q, rw_d;
  logic [23:0]      tx_q, tx_d;
  logic [19:0]      rx_q, rx_d;
  logic             pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [19:0]      rdata_q, rdata_d;
  logic             ss_q, ss_d;
  logic             sclk_q, sclk_d;
  logic             oe_q, oe_d;
  logic             sda_q, sda_d;
  logic [4:0]       last_slot_s;

  assign last_slot_s = rw_q ? RD_SLOTS : WR_SLOTS;

  // Next-state, shift/sample and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    rw_d    = rw_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    pend_d  = pend_q;
    rdata_d = rdata_q;
    sda_d   = sda_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Slot 1 (the flag bit) goes out on the accept edge itself.
          state_d = SHIFT;
          slot_d  = 5'd1;
          cnt_d   = CNT_ZERO;
          rw_d    = rw;
          tx_d    = {addr, wdata};
          sda_d   = rw;
          pend_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // Read data is taken on the last high-phase cycle of slots 8..27.
        if (rw_q && (cnt_q == PER_LAST) && (slot_q >= SAMP_FIRST)) begin
          rx_d = {rx_q[18:0], spi_sda};
        end else begin
          rx_d = rx_q;
        end
        if (cnt_q == PER_LAST) begin
          cnt_d = CNT_ZERO;
          if (slot_q == last_slot_s) begin
            state_d = TAIL;
          end else begin
            slot_d = slot_q + 5'd1;
            sda_d  = tx_q[23];
            tx_d   = {tx_q[22:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      TAIL: begin
        if (cnt_q == LOW_LAST) begin
          state_d = GAP;
          cnt_d   = CNT_ZERO;
          slot_d  = 5'd0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      GAP: begin
        if (cnt_q == PER_LAST) begin
          cnt_d = CNT_ZERO;
          if (slot_q == 5'd1) begin
            // A flush after reset has no pending request, so no done.
            state_d = IDLE;
            slot_d  = 5'd0;
            done_d  = pend_q;
            pend_d  = 1'b0;
            if (pend_q && rw_q) begin
              rdata_d = rx_q;
            end else begin
              rdata_d = rdata_q;
            end
          end else begin
            slot_d = slot_q + 5'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = GAP;
        cnt_d   = CNT_ZERO;
        slot_d  = 5'd0;
      end
    endcase

    // Pin values follow the state being entered, so they are glitch-free flops.
    busy_d = (state_d != IDLE);
    ss_d   = (state_d == SHIFT) || (state_d == TAIL);
    sclk_d = ((state_d == SHIFT) || (state_d == GAP)) && (cnt_d > LOW_LAST);
    oe_d   = (state_d == SHIFT) && (!rw_d || (slot_d <= ADDR_LAST));
  end

  // State and output registers; reset parks the block in a GAP flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= GAP;
      cnt_q   <= CNT_ZERO;
      slot_q  <= 5'd0;
      rw_q    <= 1'b0;
      tx_q    <= 24'd0;
      rx_q    <= 20'd0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 20'd0;
      ss_q    <= 1'b0;
      sclk_q  <= 1'b0;
      oe_q    <= 1'b0;
      sda_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      rw_q    <= rw_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      ss_q    <= ss_d;
      sclk_q  <= sclk_d;
      oe_q    <= oe_d;
      sda_q   <= sda_d;
    end
  end

  assign spi_sda  = oe_q ? sda_q : 1'bz;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign spi_ss   = ss_q;
  assign spi_sclk = sclk_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed bench for spi_master at CLK_DIV=4 (instance 0)
// and CLK_DIV=2 (instance 1), each wired to a behavioural 3-wire slave
// with a pull-up on its data line so a released bus reads as 1.
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic        rst_a   [2];
  logic        start_a [2];
  logic        rw_a    [2];
  logic [3:0]  addr_a  [2];
  logic [19:0] wdata_a [2];
  logic        busy_a  [2];
  logic        done_a  [2];
  logic [19:0] rdata_a [2];
  logic        ss_a    [2];
  logic        sclk_a  [2];
  logic        sda_a   [2];
  logic        ta_a    [2];
  int          rises_a [2];
  logic [24:0] frame_a [2];
  int          done_cnt[2];

  for (genvar g = 0; g < 2; g++) begin : u
    wire         spi_sda;
    logic        sclk;
    logic        ss;
    logic [4:0]  bit_cnt = 5'd0;
    logic [24:0] shreg = 25'd0;
    logic [19:0] regs [16] = '{default: 20'h0};
    logic [19:0] rd_sh = 20'd0;
    logic        sl_oe = 1'b0;
    logic        sl_bit = 1'b0;
    logic        ta = 1'b0;
    int          rises = 0;
    logic [24:0] frame = 25'd0;

    pullup pu (spi_sda);
    assign spi_sda = sl_oe ? sl_bit : 1'bz;

    spi_master #(.CLK_DIV(g == 0 ? 4 : 2)) dut (
      .clk      (clk),
      .rst_n    (rst_a[g]),
      .start    (start_a[g]),
      .rw       (rw_a[g]),
      .addr     (addr_a[g]),
      .wdata    (wdata_a[g]),
      .busy     (busy_a[g]),
      .done     (done_a[g]),
      .rdata    (rdata_a[g]),
      .spi_ss   (ss),
      .spi_sclk (sclk),
      .spi_sda  (spi_sda)
    );

    assign ss_a[g]    = ss;
    assign sclk_a[g]  = sclk;
    assign sda_a[g]   = spi_sda;
    assign ta_a[g]    = ta;
    assign rises_a[g] = rises;
    assign frame_a[g] = frame;

    // Slave samples on sclk rise; its bit counter clears on any rise with ss low.
    always @(posedge sclk) begin
      if (ss) begin
        shreg   <= {shreg[23:0], spi_sda};
        bit_cnt <= bit_cnt + 5'd1;
        rises   <= rises + 1;
      end else begin
        bit_cnt <= 5'd0;
      end
    end

    // Slave commits writes and drives read data on sclk falling edges.
    always @(negedge sclk) begin
      if (ss) begin
        if (bit_cnt == 5'd25 && !shreg[24]) begin
          frame <= shreg;
          regs[shreg[23:20]] <= shreg[19:0];
        end
        if (bit_cnt == 5'd5 && shreg[4]) begin
          ta <= 1'b1;
        end
        if (bit_cnt == 5'd7 && shreg[6]) begin
          ta     <= 1'b0;
          sl_oe  <= 1'b1;
          sl_bit <= regs[shreg[5:2]][19];
          rd_sh  <= {regs[shreg[5:2]][18:0], 1'b0};
        end else if (sl_oe && bit_cnt >= 5'd8 && bit_cnt <= 5'd26) begin
          sl_bit <= rd_sh[19];
          rd_sh  <= {rd_sh[18:0], 1'b0};
        end else if (bit_cnt == 5'd27) begin
          sl_oe <= 1'b0;
        end
      end else begin
        sl_oe <= 1'b0;
        ta    <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one cycle, sampling on the falling clk edge, with per-cycle bus checks.
  task automatic tick();
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      if (done_a[g] === 1'b1) done_cnt[g]++;
      if (ss_a[g] === 1'b1) chk("sda_known", {31'd0, $isunknown(sda_a[g])}, 32'd0);
      if (ta_a[g] === 1'b1) chk("turnaround_released", {31'd0, sda_a[g]}, 32'd1);
    end
  endtask

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    while (busy_a[g] === 1'b1 && n < 400) begin
      n++;
      tick();
    end
    chk("idle_reached", {31'd0, busy_a[g]}, 32'd0);
  endtask

  task automatic xfer(input int g, input logic rw, input logic [3:0] a, input logic [19:0] wd,
                      input logic keep, input logic intrude, output logic [19:0] rd);
    int n, d0, r0, h, exp_len, exp_rises;
    h         = (g == 0) ? 4 : 2;
    exp_rises = rw ? 27 : 25;
    exp_len   = 2 * h * exp_rises + 5 * h;
    d0        = done_cnt[g];
    r0        = rises_a[g];
    start_a[g] = 1'b1;
    rw_a[g]    = rw;
    addr_a[g]  = a;
    wdata_a[g] = wd;
    tick();
    if (!keep) start_a[g] = 1'b0;
    chk("accept_busy", {31'd0, busy_a[g]}, 32'd1);
    chk("accept_ss", {31'd0, ss_a[g]}, 32'd1);
    n = 0;
    while (busy_a[g] === 1'b1 && n < 2000) begin
      if (n < 8) chk("sclk_phase", {31'd0, sclk_a[g]}, 32'((n / h) % 2));
      if (intrude && n == 40) begin
        start_a[g] = 1'b1;
        rw_a[g]    = ~rw;
        addr_a[g]  = a + 4'd1;
        wdata_a[g] = ~wd;
      end else if (intrude && n == 43) begin
        start_a[g] = 1'b0;
      end
      n++;
      tick();
    end
    chk("busy_len", n, exp_len);
    chk("done_pulse", {31'd0, done_a[g]}, 32'd1);
    chk("done_count", done_cnt[g] - d0, 32'd1);
    chk("rise_count", rises_a[g] - r0, exp_rises);
    rd = rdata_a[g];
  endtask

  logic [19:0] rd;
  logic [19:0] exp_v [16];
  int d0;

  initial begin
    for (int g = 0; g < 2; g++) begin
      rst_a[g]   = 1'b0;
      start_a[g] = 1'b0;
      rw_a[g]    = 1'b0;
      addr_a[g]  = 4'd0;
      wdata_a[g] = 20'd0;
      done_cnt[g] = 0;
    end
    repeat (3) tick();
    for (int g = 0; g < 2; g++) begin
      chk("rst_ss", {31'd0, ss_a[g]}, 32'd0);
      chk("rst_sclk", {31'd0, sclk_a[g]}, 32'd0);
      chk("rst_busy", {31'd0, busy_a[g]}, 32'd0);
      chk("rst_done", {31'd0, done_a[g]}, 32'd0);
      chk("rst_rdata", {12'd0, rdata_a[g]}, 32'd0);
      chk("rst_sda_released", {31'd0, sda_a[g]}, 32'd1);
      rst_a[g] = 1'b1;
    end
    tick();
    tick();
    for (int g = 0; g < 2; g++) chk("flush_busy", {31'd0, busy_a[g]}, 32'd1);
    wait_idle(0);
    wait_idle(1);
    for (int g = 0; g < 2; g++) chk("flush_no_done", done_cnt[g], 32'd0);

    // Write then read register 3.
    xfer(0, 1'b0, 4'd3, 20'hA5A5A, 1'b0, 1'b0, rd);
    chk("write_frame_bits", {7'd0, frame_a[0]}, 32'h003A5A5A);
    chk("rdata_before_read", {12'd0, rd}, 32'd0);
    xfer(0, 1'b1, 4'd3, 20'h00000, 1'b0, 1'b0, rd);
    chk("read_reg3", {12'd0, rd}, 32'hA5A5A);
    tick();
    chk("rdata_hold", {12'd0, rdata_a[0]}, 32'hA5A5A);

    // Back-to-back frames with start held across done, boundary addresses.
    xfer(0, 1'b0, 4'd0, 20'h00001, 1'b1, 1'b0, rd);
    chk("rdata_hold_write", {12'd0, rd}, 32'hA5A5A);
    xfer(0, 1'b0, 4'd15, 20'h80000, 1'b1, 1'b0, rd);
    xfer(0, 1'b1, 4'd0, 20'h00000, 1'b1, 1'b0, rd);
    chk("read_reg0", {12'd0, rd}, 32'h00001);
    xfer(0, 1'b1, 4'd15, 20'h00000, 1'b0, 1'b0, rd);
    chk("read_reg15", {12'd0, rd}, 32'h80000);

    // A request while busy must be dropped, not queued.
    d0 = done_cnt[0];
    xfer(0, 1'b1, 4'd15, 20'h00000, 1'b0, 1'b1, rd);
    chk("read_reg15_intruded", {12'd0, rd}, 32'h80000);
    repeat (20) tick();
    chk("no_extra_frame", {31'd0, busy_a[0]}, 32'd0);
    chk("single_done", done_cnt[0] - d0, 32'd1);
    chk("rdata_unchanged", {12'd0, rdata_a[0]}, 32'h80000);
    xfer(0, 1'b1, 4'd0, 20'h00000, 1'b0, 1'b0, rd);
    chk("reg0_not_overwritten", {12'd0, rd}, 32'h00001);

    // Reset in slot 12 of a write must not disturb the slave register.
    xfer(0, 1'b0, 4'd7, 20'h11111, 1'b0, 1'b0, rd);
    d0 = done_cnt[0];
    start_a[0] = 1'b1;
    rw_a[0]    = 1'b0;
    addr_a[0]  = 4'd7;
    wdata_a[0] = 20'hFFFFF;
    tick();
    start_a[0] = 1'b0;
    repeat (90) tick();
    chk("mid_frame_ss", {31'd0, ss_a[0]}, 32'd1);
    rst_a[0] = 1'b0;
    repeat (3) tick();
    chk("abort_ss", {31'd0, ss_a[0]}, 32'd0);
    chk("abort_sclk", {31'd0, sclk_a[0]}, 32'd0);
    chk("abort_busy", {31'd0, busy_a[0]}, 32'd0);
    chk("abort_rdata", {12'd0, rdata_a[0]}, 32'd0);
    rst_a[0] = 1'b1;
    tick();
    tick();
    chk("abort_flush_busy", {31'd0, busy_a[0]}, 32'd1);
    wait_idle(0);
    chk("abort_no_done", done_cnt[0] - d0, 32'd0);
    xfer(0, 1'b1, 4'd7, 20'h00000, 1'b0, 1'b0, rd);
    chk("reg7_unchanged", {12'd0, rd}, 32'h11111);
    xfer(0, 1'b0, 4'd7, 20'h12345, 1'b0, 1'b0, rd);
    xfer(0, 1'b1, 4'd7, 20'h00000, 1'b0, 1'b0, rd);
    chk("reg7_after_reset", {12'd0, rd}, 32'h12345);

    // CLK_DIV=2 sweep over every address.
    for (int a = 0; a < 16; a++) begin
      exp_v[a] = 20'h13579 * 20'(a + 1) ^ {16'd0, 4'(a)};
      xfer(1, 1'b0, 4'(a), exp_v[a], 1'b0, 1'b0, rd);
    end
    for (int a = 0; a < 16; a++) begin
      xfer(1, 1'b1, 4'(a), 20'h00000, 1'b0, 1'b0, rd);
      chk("sweep_read", {12'd0, rd}, {12'd0, exp_v[a]});
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Single-clock SPI initiator for the team's 3-wire SPI register slave: 16 × 20-bit registers, active-high `spi_ss`, and a shared bidirectional `spi_sda`. The block turns a parallel request (`rw`, `addr`, `wdata`) into a write or read frame, and returns read data on `rdata`. It sits between system-clock control logic and the external slave pins.

## Interface
- `CLK_DIV`, default 4: half-period of `spi_sclk` in `clk` cycles (H). Legal range is 2 or more.
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst_n` in 1: synchronous reset, active-low.
- `start` in 1: request strobe. Accepted only when `busy`=0.
- `rw` in 1: 0 = write, 1 = read. Latched on accept.
- `addr` in 4: register address. Latched on accept.
- `wdata` in 20: write data. Latched on accept.
- `busy` out 1: transaction or flush in progress.
- `done` out 1: one-cycle pulse at the end of each transaction.
- `rdata` out 20: last read result. Holds its value until the next read completes.
- `spi_ss` out 1: slave select, active-high, idle 0.
- `spi_sclk` out 1: serial clock, idle 0.
- `spi_sda` inout 1: serial data. Driven by the master when its internal `oe`=1, otherwise `1'bz`.

## Operation
- States: IDLE, SHIFT, TAIL, GAP.
- Frame format, MSB first on `spi_sda`:
  - flag (0 = write, 1 = read),
  - then `addr[3:0]`,
  - then, for a write only, `wdata[19:0]`.
- Frame length N in `spi_sclk` periods: write N=25, read N=27.
- Bit slot n=1..N is one `spi_sclk` period: low phase of H cycles, then high phase of H cycles.
- Master drive timing:
  - The master changes `spi_sda` on the first `clk` cycle of each low phase.
  - The slave samples on the `spi_sclk` rising edge.
- Write frame: `oe`=1 for slots 1..25, carrying flag, addr, and wdata.
- Read frame:
  - `oe`=1 for slots 1..5 (flag, addr).
  - `oe`=0 from the start of slot 6; slots 6 and 7 are turnaround.
  - The slave drives from the falling edge that ends slot 7.
  - The master samples `spi_sda` on the last `clk` cycle of the high phase of slots 8..27, shifting MSB first into an internal register: slot 8 = bit 19, slot 27 = bit 0.
  - The shift register is copied to `rdata` when `done` pulses.
- Transitions:
  - IDLE → SHIFT on `start`=1. On that edge `spi_ss`=1, slot-1 data is placed on `spi_sda`, and `rw`/`addr`/`wdata` are latched.
  - SHIFT → TAIL after the high phase of slot N. `spi_sclk` falls; this falling edge commits the slave write or ends the slave's read drive. `oe`=0.
  - TAIL holds `spi_ss`=1 and `spi_sclk`=0 for H cycles, then goes to GAP.
  - GAP drives `spi_ss`=0 and issues 2 full `spi_sclk` periods (4H cycles) so that the slave's bit counter clears, then returns to IDLE.
- Reset:
  - While `rst_n`=0: `spi_ss`=0, `spi_sclk`=0, `oe`=0, `busy`=0, `done`=0, `rdata`=0.
  - On release the block enters GAP (flush, `busy`=1, no `done`). This also covers a reset in the middle of a frame.
- `start` while `busy`=1 is ignored. It is not queued.

## Timing
- `busy`=1 for exactly 2HN+5H cycles, starting the cycle after `start` is accepted.
  - Write at H=4: 220 cycles.
  - Read at H=4: 236 cycles.
- `done`=1 for one cycle, in the first cycle with `busy`=0. `rdata` is valid in that same cycle for reads.
- `start`=1 in the `done` cycle is accepted. Back-to-back frames are therefore separated by GAP and that one cycle.
- `spi_sda` never has both drivers active: the master releases 2 slots before the slave drives, and the slave releases on the TAIL falling edge, before GAP.
- Slot counter and phase counter are sized for N ≤ 27 and `CLK_DIV`.

## Test plan
- Write reg 3 = 20'hA5A5A, then read reg 3. Required: 25 rising edges with SDA pattern 0,0011,A5A5A; then a read returns `rdata`=20'hA5A5A; `done` pulses once per transaction; busy lengths are 220 and 236 at H=4.
- Write regs 0 and 15 with 20'h00001 and 20'h80000 (start held high across `done`), then read both. Required: the values read back are exact, and the second frame starts the cycle after `done`.
- Assert `start` with a new request while `busy`=1. Required: no extra frame, `rdata` unchanged, exactly one `done`.
- Pulse `rst_n`=0 during slot 12 of a write. Required: the slave register is unchanged, a GAP flush follows, and the next read of 20'h12345 written afterwards is correct.
- `CLK_DIV`=2, full write/read sweep of all 16 addresses. Required: all match; sclk high and low phases are each 2 cycles.
- Bench check on every cycle of every scenario: no X on `spi_sda` while either side drives, and `spi_sda`=z during turnaround slots 6 and 7.
